// File: rtl/mult_div_unit_pkg.sv
// mult_div_unit_pkg: shared encodings for the E-stage multiply/divide unit.
//   md_cal_e   : M_D_Cal op codes (none / MULT / DIV / MADD)
//   md_read_e  : M_D_Read codes (none / LO_Read / HI_Read)
//   md_wr_e    : Other_Reg_Wr codes (none / RegLO / RegHI)
//   md_state_e : unit FSM states
// Optional feature macro: MDU_MADD_EN (enables M_D_Cal = 11 as MADD).
package mult_div_unit_pkg;

   typedef enum logic [1:0] {
      MD_NONE = 2'b00,
      MD_MULT = 2'b01,
      MD_DIV  = 2'b10,
      MD_MADD = 2'b11
   } md_cal_e;

   typedef enum logic [1:0] {
      RD_NONE = 2'b00,
      LO_READ = 2'b01,
      HI_READ = 2'b10,
      RD_ILL  = 2'b11
   } md_read_e;

   typedef enum logic [1:0] {
      WR_NONE = 2'b00,
      REG_LO  = 2'b01,
      REG_HI  = 2'b10,
      WR_ILL  = 2'b11
   } md_wr_e;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } md_state_e;

   // True for M_D_Cal codes this build actually executes.
   function automatic logic op_supported(logic [1:0] cal);
`ifdef MDU_MADD_EN
      return cal != MD_NONE;
`else
      return (cal == MD_MULT) || (cal == MD_DIV);
`endif
   endfunction

endpackage

// File: rtl/mult_div_unit_mdu_calc.sv
// mdu_calc: combinational result generator for mult_div_unit.
//   a, b      : operands (rs, rt)
//   op        : M_D_Cal code
//   is_signed : signed MULT/DIV when set (MADD is always signed)
//   hi, lo    : current HI/LO (MADD accumulator, kept on div-by-zero)
//   result    : 64-bit {HI,LO} result
//   div_zero  : b == 0
// Optional feature macro: MDU_MADD_EN (adds the MADD accumulate adder).
module mdu_calc
   import mult_div_unit_pkg::*;
(
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [1:0]  op,
   input  logic        is_signed,
   input  logic [31:0] hi,
   input  logic [31:0] lo,
   output logic [63:0] result,
   output logic        div_zero
);

   logic        neg_a, neg_b;
   logic [31:0] mag_a, mag_b, safe_b;
   logic [31:0] quo_mag, rem_mag, quo, rem;
   logic [63:0] sprod, uprod, prod;

   always_comb begin
      // Signed division runs on magnitudes; unsigned is the same path with
      // no negation. 0x80000000 / -1 naturally wraps back to 0x80000000.
      neg_a    = is_signed & a[31];
      neg_b    = is_signed & b[31];
      mag_a    = neg_a ? -a : a;
      mag_b    = neg_b ? -b : b;
      div_zero = (b == '0);
      safe_b   = div_zero ? 32'd1 : mag_b;
      quo_mag  = mag_a / safe_b;
      rem_mag  = mag_a % safe_b;
      quo      = (neg_a ^ neg_b) ? -quo_mag : quo_mag;
      rem      = neg_a ? -rem_mag : rem_mag;

      // Low 64 bits of the sign-extended product equal the signed product.
      sprod    = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      uprod    = {32'b0, a} * {32'b0, b};
      prod     = is_signed ? sprod : uprod;

      result   = {hi, lo};
      case (op)
         MD_MULT: result = prod;
         MD_DIV:  result = div_zero ? {hi, lo} : {rem, quo};
`ifdef MDU_MADD_EN
         MD_MADD: result = {hi, lo} + sprod;
`endif
         default: result = {hi, lo};
      endcase
   end

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: E-stage multiply/divide unit with architectural HI/LO.
//   clk, reset   : rising-edge clock, synchronous active-high reset
//   M_D_Cal      : op (00 none, 01 MULT, 10 DIV, 11 MADD)
//   is_signed    : signed operation select
//   M_D_Read     : 01 read LO, 10 read HI onto rd_data
//   Other_Reg_Wr : 01 mtlo, 10 mthi (writes A)
//   A, B         : forwarded rs / rt
//   busy         : operation in flight
//   start        : op accepted this cycle
//   rd_data      : HI/LO read data, 0 when no read
// Optional feature macro: MDU_MADD_EN (MADD support; otherwise 11 is a no-op).
module mult_div_unit
   import mult_div_unit_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10,
   parameter int unsigned CNT_W       = 4
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  M_D_Cal,
   input  logic        is_signed,
   input  logic [1:0]  M_D_Read,
   input  logic [1:0]  Other_Reg_Wr,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        busy,
   output logic        start,
   output logic [31:0] rd_data
);

   md_state_e        state, state_nx;
   logic [CNT_W-1:0] cnt;
   logic             last;
   logic [31:0]      hi, lo, pend_hi, pend_lo;
   logic             pend_dz;
   logic [63:0]      calc_result;
   logic             calc_dz;

   mdu_calc u_calc (
      .a         (A),
      .b         (B),
      .op        (M_D_Cal),
      .is_signed (is_signed),
      .hi        (hi),
      .lo        (lo),
      .result    (calc_result),
      .div_zero  (calc_dz)
   );

   always_comb last = (cnt == CNT_W'(1));

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = RUN;
         RUN:     if (last)  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Outputs
   always_comb begin
      busy  = (state == RUN);
      start = !busy && op_supported(M_D_Cal);
   end

   // Result is captured at acceptance so operand changes while running have
   // no effect; an accepted op takes priority over a same-cycle mthi/mtlo.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt     <= '0;
         hi      <= '0;
         lo      <= '0;
         pend_hi <= '0;
         pend_lo <= '0;
         pend_dz <= 1'b0;
      end else if (start) begin
         cnt     <= (M_D_Cal == MD_DIV) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
         pend_hi <= calc_result[63:32];
         pend_lo <= calc_result[31:0];
         pend_dz <= calc_dz && (M_D_Cal == MD_DIV);
      end else if (busy) begin
         cnt <= cnt - CNT_W'(1);
         if (last && !pend_dz) begin
            hi <= pend_hi;
            lo <= pend_lo;
         end
      end else begin
         case (Other_Reg_Wr)
            REG_HI:  hi <= A;
            REG_LO:  lo <= A;
            default: ;
         endcase
      end
   end

   always_comb begin
      case (M_D_Read)
         LO_READ: rd_data = lo;
         HI_READ: rd_data = hi;
         default: rd_data = '0;
      endcase
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed self-checking bench for mult_div_unit.
// Optional feature macro: MDU_MADD_EN (selects the MADD-enabled expectations).
module tb_mult_div_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  M_D_Cal;
   logic        is_signed;
   logic [1:0]  M_D_Read;
   logic [1:0]  Other_Reg_Wr;
   logic [31:0] A, B;
   logic        busy, start;
   logic [31:0] rd_data;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .M_D_Cal      (M_D_Cal),
      .is_signed    (is_signed),
      .M_D_Read     (M_D_Read),
      .Other_Reg_Wr (Other_Reg_Wr),
      .A            (A),
      .B            (B),
      .busy         (busy),
      .start        (start),
      .rd_data      (rd_data)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_hilo(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      M_D_Read = 2'b10;
      #1 check({tag, "_hi"}, rd_data, exp_hi);
      M_D_Read = 2'b01;
      #1 check({tag, "_lo"}, rd_data, exp_lo);
      M_D_Read = 2'b00;
   endtask

   // Presents an op, checks start, clocks it in and clears the op inputs.
   task automatic issue(input string tag, input logic [1:0] cal, input logic sgn,
                        input logic [31:0] a, input logic [31:0] b);
      M_D_Cal = cal; is_signed = sgn; A = a; B = b;
      #1 check({tag, "_start"}, {31'b0, start}, 32'd1);
      tick();
      M_D_Cal = 2'b00;
   endtask

   // Counts busy cycles after acceptance, bounded.
   task automatic wait_idle(input string tag, input int unsigned exp_cycles);
      int unsigned cycles = 0;
      while (busy && cycles < 50) begin
         tick();
         cycles++;
      end
      check({tag, "_cycles"}, cycles, exp_cycles);
   endtask

   task automatic move_to(input logic [1:0] which, input logic [31:0] val);
      Other_Reg_Wr = which; A = val;
      tick();
      Other_Reg_Wr = 2'b00;
   endtask

   initial begin
      reset = 1'b1; M_D_Cal = 2'b00; is_signed = 1'b0; M_D_Read = 2'b00;
      Other_Reg_Wr = 2'b00; A = '0; B = '0;
      tick(); tick();
      reset = 1'b0;
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_start", {31'b0, start}, 32'd0);
      check_hilo("rst", 32'h0, 32'h0);
      check("rd_none", rd_data, 32'h0);

      // signed mult -2 * 3 = -6
      issue("mult_s", 2'b01, 1'b1, 32'hFFFF_FFFE, 32'd3);
      check("mult_s_busy", {31'b0, busy}, 32'd1);
      wait_idle("mult_s", 5);
      check_hilo("mult_s", 32'hFFFF_FFFF, 32'hFFFF_FFFA);

      // unsigned 0xFFFFFFFF * 2
      issue("multu", 2'b01, 1'b0, 32'hFFFF_FFFF, 32'd2);
      wait_idle("multu", 5);
      check_hilo("multu", 32'h0000_0001, 32'hFFFF_FFFE);

      // signed -7 / 2 -> q = -3, r = -1
      issue("div_s", 2'b10, 1'b1, 32'hFFFF_FFF9, 32'd2);
      wait_idle("div_s", 10);
      check_hilo("div_s", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

      // divu by zero keeps HI/LO
      issue("divu0", 2'b10, 1'b0, 32'd5, 32'd0);
      wait_idle("divu0", 10);
      check_hilo("divu0", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

      // most-negative / -1
      issue("div_ovf", 2'b10, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_idle("div_ovf", 10);
      check_hilo("div_ovf", 32'h0, 32'h8000_0000);

      // unsigned 100 / 7 -> q = 14, r = 2
      issue("divu", 2'b10, 1'b0, 32'd100, 32'd7);
      wait_idle("divu", 10);
      check_hilo("divu", 32'd2, 32'd14);

      // operands change and a new mult is presented while busy
      issue("latch", 2'b01, 1'b1, 32'd7, 32'd6);
      A = 32'hDEAD_BEEF; B = 32'h1234_5678; M_D_Cal = 2'b01;
      #1 check("busy_start", {31'b0, start}, 32'd0);
      wait_idle("latch", 5);
      M_D_Cal = 2'b00;
      check_hilo("latch", 32'h0, 32'd42);

      // mthi / mtlo and reads
      move_to(2'b10, 32'h1234_5678);
      move_to(2'b01, 32'hCAFE_F00D);
      check_hilo("mt", 32'h1234_5678, 32'hCAFE_F00D);

      // illegal encodings are no-ops
      M_D_Read = 2'b11;
      #1 check("rd_ill", rd_data, 32'h0);
      M_D_Read = 2'b00;
      move_to(2'b11, 32'h5555_AAAA);
      check_hilo("wr_ill", 32'h1234_5678, 32'hCAFE_F00D);

      // mthi while busy (div by zero) is ignored
      issue("mt_busy", 2'b10, 1'b0, 32'd9, 32'd0);
      Other_Reg_Wr = 2'b10; A = 32'h1111_1111;
      wait_idle("mt_busy", 10);
      Other_Reg_Wr = 2'b00;
      check_hilo("mt_busy", 32'h1234_5678, 32'hCAFE_F00D);

      // reset in the 3rd busy cycle of a div
      issue("rst_mid", 2'b10, 1'b0, 32'd100, 32'd7);
      tick(); tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("rst_mid_busy", {31'b0, busy}, 32'd0);
      check_hilo("rst_mid", 32'h0, 32'h0);
      repeat (12) tick();
      check("rst_late_busy", {31'b0, busy}, 32'd0);
      check_hilo("rst_late", 32'h0, 32'h0);

      // op and mtlo in the same cycle: op wins
      M_D_Cal = 2'b01; is_signed = 1'b0; A = 32'd3; B = 32'd4; Other_Reg_Wr = 2'b01;
      tick();
      M_D_Cal = 2'b00; Other_Reg_Wr = 2'b00;
      wait_idle("op_wins", 5);
      check_hilo("op_wins", 32'h0, 32'd12);

      // MADD
      move_to(2'b10, 32'h0);
      move_to(2'b01, 32'hFFFF_FFFF);
`ifdef MDU_MADD_EN
      issue("madd", 2'b11, 1'b1, 32'd1, 32'd1);
      wait_idle("madd", 5);
      check_hilo("madd", 32'h1, 32'h0);
`else
      M_D_Cal = 2'b11; is_signed = 1'b1; A = 32'd1; B = 32'd1;
      #1 check("madd_off_start", {31'b0, start}, 32'd0);
      tick();
      M_D_Cal = 2'b00;
      check("madd_off_busy", {31'b0, busy}, 32'd0);
      repeat (6) tick();
      check_hilo("madd_off", 32'h0, 32'hFFFF_FFFF);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
